// File: rtl/ham_pkg.sv
// ham_pkg: shared constants and types for the Hamming unit.
// Imported by ham_seq_unit and nib_popcnt.
package ham_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ham_state_e;

  localparam int HAM_NIBBLES = 8;
  localparam int HAM_ACC_W   = 6;
  localparam int HAM_CNT_W   = 3;
  localparam int HAM_PC_W    = 3;

  localparam logic HAM_MODE_DIST = 1'b0;
  localparam logic HAM_MODE_WGT  = 1'b1;

  localparam logic [HAM_CNT_W-1:0] HAM_CNT_LAST =
    HAM_CNT_W'(HAM_NIBBLES - 1);

endpackage

// File: rtl/ham_seq_unit_nib_popcnt.sv
// nib_popcnt: combinational 4-bit population count.
// Feeds the per-cycle accumulate step of ham_seq_unit.
module nib_popcnt
  import ham_pkg::*;
(
  input  logic [3:0]          nib_i,
  output logic [HAM_PC_W-1:0] cnt_o
);

  // sum of the four bits, 0..4
  assign cnt_o = HAM_PC_W'(nib_i[0])
               + HAM_PC_W'(nib_i[1])
               + HAM_PC_W'(nib_i[2])
               + HAM_PC_W'(nib_i[3]);

endmodule

// File: rtl/ham_seq_unit.sv
// ham_seq_unit: nibble-serial Hamming distance/weight unit.
// Optional macro HAM_EARLY_EXIT_EN ends RUN once x is all zero.
module ham_seq_unit
  import ham_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        z
);

  ham_state_e state_q, state_d;

  logic [31:0]          x_q, x_d;
  logic [HAM_ACC_W-1:0] acc_q, acc_d;
  logic [HAM_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          s_q, s_d;
  logic                 z_q, z_d;

  logic [HAM_PC_W-1:0]  pc;
  logic [HAM_ACC_W-1:0] acc_nx;
  logic [31:0]          x_sh;
  logic                 fin;
  logic                 accept;

  nib_popcnt u_pc (
    .nib_i (x_q[3:0]),
    .cnt_o (pc)
  );

  assign acc_nx = acc_q + HAM_ACC_W'(pc);
  assign x_sh   = x_q >> 4;
  assign accept = start && (state_q != RUN);

`ifdef HAM_EARLY_EXIT_EN
  assign fin = (cnt_q == HAM_CNT_LAST) || (x_sh == '0);
`else
  assign fin = (cnt_q == HAM_CNT_LAST);
`endif

  // state register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = fin ? DONE : RUN;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == RUN):  busy = 1'b1;
      (state_q == DONE): done = 1'b1;
      default: ;
    endcase
  end

  // datapath next state: latch, accumulate, publish result
  always_comb begin
    x_d   = x_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    z_d   = z_q;
    if (accept) begin
      x_d   = (mode == HAM_MODE_WGT) ? a : (a ^ b);
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      x_d   = x_sh;
      acc_d = acc_nx;
      cnt_d = cnt_q + 1'b1;
      if (fin) begin
        s_d = {{(32-HAM_ACC_W){1'b0}}, acc_nx};
        z_d = (acc_nx == '0);
      end
    end
  end

  // datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      s_q   <= '0;
      z_q   <= 1'b1;
    end else begin
      x_q   <= x_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
      z_q   <= z_d;
    end
  end

  assign s = s_q;
  assign z = z_q;

endmodule
